// File: rtl/reg_op_pkg.sv
// rtl/reg_op_pkg.sv - shared types and defaults for the register-op sequencer
// Contents: op_t (3-bit ALU op codes), state_t (sequencer states),
//           DATA_W_DEF / ADDR_W_DEF default widths.
package reg_op_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_XOR   = 3'd4,
        OP_NOT   = 3'd5,
        OP_PASSB = 3'd6,
        OP_SHL1  = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/reg_op_sequencer_if.sv
// rtl/reg_op_sequencer_if.sv - command and register-file bus of the sequencer
// Command side : start, op, src_a, src_b, dst (to sequencer);
//                busy, done, result, ovf (from sequencer)
// Regfile side : rd1, rd2 (to sequencer); ra1, ra2, wa3, wd3, we3 (from sequencer)
// modport slave  : the sequencer
// modport master : the requester / register file environment
interface reg_op_sequencer_if
    import reg_op_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              start;
    op_t               op;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [ADDR_W-1:0] wa3;
    logic [DATA_W-1:0] wd3;
    logic              we3;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              ovf;

    modport slave (
        input  start, op, src_a, src_b, dst, rd1, rd2,
        output ra1, ra2, wa3, wd3, we3, busy, done, result, ovf
    );

    modport master (
        output start, op, src_a, src_b, dst, rd1, rd2,
        input  ra1, ra2, wa3, wd3, we3, busy, done, result, ovf
    );

endinterface

// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - combinational two-operand ALU used in the EXEC step
// Ports: a, b (operands), op (op_t) -> y (result, modulo 2**DATA_W),
//        ovf (signed overflow for ADD/SUB, 0 otherwise)
module exec_alu
    import reg_op_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  op_t               op,
    output logic [DATA_W-1:0] y,
    output logic              ovf
);

    localparam int MSB = DATA_W - 1;

    always_comb begin
        y   = '0;
        ovf = 1'b0;
        case (op)
            OP_ADD: begin
                y   = a + b;
                // same-sign operands producing a different-sign sum
                ovf = (a[MSB] == b[MSB]) && (y[MSB] != a[MSB]);
            end
            OP_SUB: begin
                y   = a - b;
                // opposite-sign operands where the sign of A is lost
                ovf = (a[MSB] != b[MSB]) && (y[MSB] != a[MSB]);
            end
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NOT:   y = ~a;
            OP_PASSB: y = b;
            OP_SHL1:  y = {a[MSB-1:0], 1'b0};
            default: begin
                y   = '0;
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/reg_op_sequencer.sv
// rtl/reg_op_sequencer.sv - read/execute/write-back sequencer beside an 8x8 register file
// Ports: clk, rst (synchronous, active high),
//        bus (reg_op_sequencer_if.slave): command in, status/result out,
//        register-file read ports (ra1/rd1, ra2/rd2) and write port (wa3/wd3/we3).
// Flow: IDLE -start-> READ -> EXEC -> WRITE -> DONE -> IDLE, all outputs registered.
module reg_op_sequencer
    import reg_op_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    reg_op_sequencer_if.slave bus
);

    state_t            state_q,  state_d;
    op_t               op_q,     op_d;
    logic [ADDR_W-1:0] dst_q,    dst_d;
    logic [DATA_W-1:0] opa_q,    opa_d;
    logic [DATA_W-1:0] opb_q,    opb_d;
    logic [DATA_W-1:0] res_q,    res_d;
    logic              ovf_n_q,  ovf_n_d;
    logic [ADDR_W-1:0] ra1_q,    ra1_d;
    logic [ADDR_W-1:0] ra2_q,    ra2_d;
    logic [ADDR_W-1:0] wa3_q,    wa3_d;
    logic [DATA_W-1:0] wd3_q,    wd3_d;
    logic              we3_q,    we3_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              ovf_q,    ovf_d;

    logic [DATA_W-1:0] alu_y;
    logic              alu_ovf;

    exec_alu #(.DATA_W(DATA_W)) u_alu (
        .a   (opa_q),
        .b   (opb_q),
        .op  (op_q),
        .y   (alu_y),
        .ovf (alu_ovf)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dst_d    = dst_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        res_d    = res_q;
        ovf_n_d  = ovf_n_q;
        ra1_d    = ra1_q;
        ra2_d    = ra2_q;
        wa3_d    = wa3_q;
        wd3_d    = wd3_q;
        we3_d    = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // read addresses are loaded here so they are valid
                    // for the whole READ cycle; ra1/ra2 double as the
                    // latched source addresses
                    op_d    = bus.op;
                    dst_d   = bus.dst;
                    ra1_d   = bus.src_a;
                    ra2_d   = bus.src_b;
                    busy_d  = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                opa_d   = bus.rd1;
                opb_d   = bus.rd2;
                state_d = EXEC;
            end
            EXEC: begin
                // write port is set up one edge early so it is
                // presented during the WRITE cycle
                res_d   = alu_y;
                ovf_n_d = alu_ovf;
                wa3_d   = dst_q;
                wd3_d   = alu_y;
                we3_d   = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                result_d = res_q;
                ovf_d    = ovf_n_q;
                done_d   = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            dst_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            ovf_n_q  <= 1'b0;
            ra1_q    <= '0;
            ra2_q    <= '0;
            wa3_q    <= '0;
            wd3_q    <= '0;
            we3_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            res_q    <= res_d;
            ovf_n_q  <= ovf_n_d;
            ra1_q    <= ra1_d;
            ra2_q    <= ra2_d;
            wa3_q    <= wa3_d;
            wd3_q    <= wd3_d;
            we3_q    <= we3_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.ra1    = ra1_q;
    assign bus.ra2    = ra2_q;
    assign bus.wa3    = wa3_q;
    assign bus.wd3    = wd3_q;
    assign bus.we3    = we3_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.ovf    = ovf_q;

endmodule
